conv_result_collector: RTL and testbench

Receiving end of the spatial convolution core's per-kernel output stream. It captures `data_o`/`data_valid_o` lanes from the last `spatial_conv_core`, applies per-lane back-pressure via `hold_data`, and serialises results round-robin into a single-port output RAM. The RAM layout is kernel-major: lane k occupies addresses k*OUTPUT_SIZE through (k+1)*OUTPUT_SIZE-1. When all lanes are complete, it appends a cycle-count word at a dedicated stats address.

---
 rtl/conv_result_collector.sv | 167 ++++++++++++++++
 tb/tb_conv_result_collector.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Collects per-kernel result lanes from the convolution core and serialises them round-robin
// into a kernel-major output RAM, finishing with a cycle-count stats word.
module conv_result_collector #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned N_KERNELS   = 64,
  parameter int unsigned OUTPUT_SIZE = 25
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [N_KERNELS*DATA_WIDTH-1:0] data_i,
  input  logic [N_KERNELS-1:0]            data_valid_i,
  output logic [N_KERNELS-1:0]            hold_data_o,
  input  logic                            start_i,
  output logic                            ram_wren_o,
  output logic [ADDR_WIDTH-1:0]           ram_wraddress_o,
  output logic [DATA_WIDTH-1:0]           ram_data_o,
  output logic                            done_o,
  output logic                            overrun_o
);

  localparam int unsigned KW = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int unsigned CW = $clog2(OUTPUT_SIZE + 1);
  localparam logic [CW-1:0]         OutSizeC  = CW'(OUTPUT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OutSizeA  = ADDR_WIDTH'(OUTPUT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] StatsAddr = ADDR_WIDTH'(N_KERNELS * OUTPUT_SIZE);
  localparam logic [KW-1:0]         LastLane  = KW'(N_KERNELS - 1);

  typedef enum logic [1:0] {StCollect, StWriteStats, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cap_data_q [N_KERNELS];
  logic [N_KERNELS-1:0]  cap_full_q;
  logic [CW-1:0]         acc_q [N_KERNELS];
  logic [CW-1:0]         wr_q [N_KERNELS];
  logic [KW-1:0]         rr_q;
  logic [DATA_WIDTH-1:0] cyc_q;
  logic                  overrun_q;
  logic                  ram_wren_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;

  logic                  sel_found;
  logic [KW-1:0]         sel_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  all_written;
  logic [N_KERNELS-1:0]  accept;
  logic [N_KERNELS-1:0]  overrun_hit;

  // Lane index `offset` positions after `base`, wrapping at N_KERNELS.
  function automatic logic [KW-1:0] lane_at(logic [KW-1:0] base, int unsigned offset);
    int unsigned pos;
    pos = 32'(base) + offset;
    if (pos >= N_KERNELS) pos = pos - N_KERNELS;
    return KW'(pos);
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < N_KERNELS; i++) begin
      if (!sel_found && cap_full_q[lane_at(rr_q, i)]) begin
        sel_found = 1'b1;
        sel_idx   = lane_at(rr_q, i);
      end
    end
    sel_addr = ADDR_WIDTH'(sel_idx) * OutSizeA + ADDR_WIDTH'(wr_q[sel_idx]);
  end

  // Words arriving while a lane is held are left with the producer, never counted.
  always_comb begin
    accept      = '0;
    overrun_hit = '0;
    all_written = 1'b1;
    for (int unsigned k = 0; k < N_KERNELS; k++) begin
      if (state_q == StCollect && data_valid_i[k] && !cap_full_q[k]) begin
        accept[k]      = (acc_q[k] != OutSizeC);
        overrun_hit[k] = (acc_q[k] == OutSizeC);
      end
      if (wr_q[k] != OutSizeC) all_written = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= StCollect;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect:    if (all_written && cap_full_q == '0) state_d = StWriteStats;
      StWriteStats: state_d = StDone;
      StDone:       if (start_i) state_d = StCollect;
      default:      state_d = StCollect;
    endcase
  end

  always_comb begin
    done_o          = (state_q == StDone);
    hold_data_o     = cap_full_q;
    overrun_o       = overrun_q;
    ram_wren_o      = ram_wren_q;
    ram_wraddress_o = ram_addr_q;
    ram_data_o      = ram_data_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cap_full_q <= '0;
      rr_q       <= '0;
      cyc_q      <= '0;
      overrun_q  <= 1'b0;
      ram_wren_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      for (int unsigned k = 0; k < N_KERNELS; k++) begin
        cap_data_q[k] <= '0;
        acc_q[k]      <= '0;
        wr_q[k]       <= '0;
      end
    end else begin
      ram_wren_q <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          if (|overrun_hit) overrun_q <= 1'b1;
          for (int unsigned k = 0; k < N_KERNELS; k++) begin
            if (accept[k]) begin
              cap_data_q[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
              cap_full_q[k] <= 1'b1;
              acc_q[k]      <= acc_q[k] + 1'b1;
            end
          end
          // Selected lane is always full, so it never collides with an accept above.
          if (sel_found) begin
            ram_wren_q          <= 1'b1;
            ram_addr_q          <= sel_addr;
            ram_data_q          <= cap_data_q[sel_idx];
            cap_full_q[sel_idx] <= 1'b0;
            wr_q[sel_idx]       <= wr_q[sel_idx] + 1'b1;
            rr_q                <= (sel_idx == LastLane) ? '0 : sel_idx + 1'b1;
          end
        end
        StWriteStats: begin
          ram_wren_q <= 1'b1;
          ram_addr_q <= StatsAddr;
          ram_data_q <= cyc_q;
        end
        StDone: begin
          if (start_i) begin
            cap_full_q <= '0;
            rr_q       <= '0;
            cyc_q      <= '0;
            overrun_q  <= 1'b0;
            for (int unsigned k = 0; k < N_KERNELS; k++) begin
              acc_q[k] <= '0;
              wr_q[k]  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: directed latency/contention cases plus randomised producer
// traffic checked against an expected kernel-major RAM image.
module tb_conv_result_collector;

  localparam int NK    = 4;
  localparam int OS    = 3;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int STATS = NK * OS;

  logic              clock = 1'b0;
  logic              reset_i;
  logic [NK*DW-1:0]  data_i;
  logic [NK-1:0]     data_valid_i;
  logic [NK-1:0]     hold_data_o;
  logic              start_i;
  logic              ram_wren_o;
  logic [AW-1:0]     ram_wraddress_o;
  logic [DW-1:0]     ram_data_o;
  logic              done_o;
  logic              overrun_o;

  int checks = 0;
  int errors = 0;

  // Reference model: expected RAM image and per-lane accepted counts.
  logic [DW-1:0] exp_mem [STATS];
  int            acc_cnt [NK];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_at [$];
  int            cyc_no = 0;
  int            stats_at = -1;
  int            early_done = 0;
  int            first_collect = 0;

  conv_result_collector #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_KERNELS  (NK),
    .OUTPUT_SIZE(OS)
  ) dut (
    .clock_i        (clock),
    .reset_i        (reset_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .hold_data_o    (hold_data_o),
    .start_i        (start_i),
    .ram_wren_o     (ram_wren_o),
    .ram_wraddress_o(ram_wraddress_o),
    .ram_data_o     (ram_data_o),
    .done_o         (done_o),
    .overrun_o      (overrun_o)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge and log any RAM write visible in that cycle.
  task automatic cycle();
    @(negedge clock);
    cyc_no++;
    if (ram_wren_o === 1'b1) begin
      log_addr.push_back(ram_wraddress_o);
      log_data.push_back(ram_data_o);
      log_at.push_back(cyc_no);
      if (ram_wraddress_o === AW'(STATS) && stats_at < 0) stats_at = cyc_no;
    end
    if (done_o === 1'b1 && stats_at < 0) early_done++;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NK; k++) acc_cnt[k] = 0;
    for (int a = 0; a < STATS; a++) exp_mem[a] = '0;
    log_addr.delete();
    log_data.delete();
    log_at.delete();
    stats_at   = -1;
    early_done = 0;
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    start_i      = 1'b0;
    data_valid_i = '0;
    data_i       = '0;
    cycle();
    cycle();
    reset_i       = 1'b0;
    first_collect = cyc_no;
    clear_model();
  endtask

  // Random producer: lanes offer words (junk while held) until each has OS accepted.
  task automatic run_lanes(input int stop_writes, input int budget);
    logic [DW-1:0] w;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (stats_at >= 0) break;
      if (stop_writes > 0 && log_addr.size() >= stop_writes) break;
      for (int k = 0; k < NK; k++) begin
        w = $urandom();
        data_i[k*DW +: DW] = w;
        data_valid_i[k]    = 1'b0;
        if (acc_cnt[k] < OS) begin
          data_valid_i[k] = ($urandom_range(0, 3) != 0);
          if (data_valid_i[k] && !hold_data_o[k]) begin
            exp_mem[k*OS + acc_cnt[k]] = w;
            acc_cnt[k]++;
          end
        end
      end
    end
    data_valid_i = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ram_wren_o !== 1'b0 || ram_wraddress_o !== '0 || ram_data_o !== '0) begin
      errors++;
      $display("FAIL reset_ram: got wren %b addr %h data %h want 0 0 0",
               ram_wren_o, ram_wraddress_o, ram_data_o);
    end
    checks++;
    if (hold_data_o !== '0 || done_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got hold %b done %b overrun %b want 0 0 0",
               hold_data_o, done_o, overrun_o);
    end
  endtask

  task automatic test_single_latency();
    do_reset();
    data_valid_i     = 4'b0100;
    data_i[2*DW +: DW] = 32'h11;
    cycle();
    data_valid_i = '0;
    checks++;
    if (hold_data_o !== 4'b0100 || ram_wren_o !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: got hold %b wren %b want 0100 0", hold_data_o, ram_wren_o);
    end
    cycle();
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wraddress_o !== 8'd6 || ram_data_o !== 32'h11) begin
      errors++;
      $display("FAIL single_t2_write: got wren %b addr %0d data %h want 1 6 11",
               ram_wren_o, ram_wraddress_o, ram_data_o);
    end
    checks++;
    if (hold_data_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_t2_hold: got %b want 0000", hold_data_o);
    end
  endtask

  task automatic test_contention();
    logic [NK-1:0] exp_hold;
    do_reset();
    data_valid_i = '1;
    for (int k = 0; k < NK; k++) data_i[k*DW +: DW] = 32'hA0 + k;
    cycle();
    data_valid_i = '0;
    checks++;
    if (hold_data_o !== 4'b1111 || ram_wren_o !== 1'b0) begin
      errors++;
      $display("FAIL contention_capture: got hold %b wren %b want 1111 0", hold_data_o, ram_wren_o);
    end
    for (int k = 0; k < NK; k++) begin
      cycle();
      exp_hold = 4'b1111 << (k + 1);
      checks++;
      if (ram_wren_o !== 1'b1 || ram_wraddress_o !== AW'(k * OS) || ram_data_o !== 32'hA0 + k ||
          hold_data_o !== exp_hold) begin
        errors++;
        $display("FAIL contention_w%0d: got wren %b addr %0d data %h hold %b want 1 %0d %h %b",
                 k, ram_wren_o, ram_wraddress_o, ram_data_o, hold_data_o, k * OS, 32'hA0 + k,
                 exp_hold);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] words [$];
    logic [DW-1:0] w;
    bit            took;
    do_reset();
    took = 1'b0;
    // An uncontested lane is held exactly in the cycle after each accept.
    for (int n = 0; n < 20; n++) begin
      cycle();
      checks++;
      if (hold_data_o[1] !== took) begin
        errors++;
        $display("FAIL bp_hold_n%0d: got %b want %b", n, hold_data_o[1], took);
      end
      if (words.size() < OS) begin
        w              = $urandom();
        data_valid_i   = 4'b0010;
        data_i[DW +: DW] = w;
        if (!took) begin
          words.push_back(w);
          took = 1'b1;
        end else begin
          took = 1'b0;
        end
      end else begin
        data_valid_i = '0;
        took         = 1'b0;
      end
    end
    checks++;
    if (log_addr.size() !== OS) begin
      errors++;
      $display("FAIL bp_count: got %0d writes want %0d", log_addr.size(), OS);
    end
    for (int i = 0; i < log_addr.size() && i < OS; i++) begin
      checks++;
      if (log_addr[i] !== AW'(OS + i) || log_data[i] !== words[i]) begin
        errors++;
        $display("FAIL bp_word%0d: got addr %0d data %h want %0d %h",
                 i, log_addr[i], log_data[i], OS + i, words[i]);
      end
    end
  endtask

  task automatic test_completion();
    bit seen [STATS];
    int n_data;
    int last_w;
    do_reset();
    run_lanes(0, 400);
    checks++;
    if (stats_at < 0) begin
      errors++;
      $display("FAIL done_stats_timeout: got no stats write want one within 400 cycles");
    end
    for (int a = 0; a < STATS; a++) seen[a] = 1'b0;
    n_data = 0;
    last_w = -1;
    for (int i = 0; i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] < AW'(STATS)) begin
        n_data++;
        last_w = log_at[i];
        if (log_data[i] !== exp_mem[log_addr[i]] || seen[log_addr[i]]) begin
          errors++;
          $display("FAIL done_word: addr %0d got %h want %h (dup %0b)",
                   log_addr[i], log_data[i], exp_mem[log_addr[i]], seen[log_addr[i]]);
        end
        seen[log_addr[i]] = 1'b1;
      end else if (log_addr[i] == AW'(STATS)) begin
        if (log_data[i] !== DW'(stats_at - first_collect - 1)) begin
          errors++;
          $display("FAIL done_cyc: got %0d want %0d", log_data[i], stats_at - first_collect - 1);
        end
      end else begin
        errors++;
        $display("FAIL done_addr: got %0d want below %0d", log_addr[i], STATS + 1);
      end
    end
    checks++;
    if (n_data !== STATS || last_w !== stats_at - 2) begin
      errors++;
      $display("FAIL done_timing: got %0d writes last at %0d want %0d writes last at %0d",
               n_data, last_w, STATS, stats_at - 2);
    end
    checks++;
    if (done_o !== 1'b1 || early_done !== 0) begin
      errors++;
      $display("FAIL done_flag: got done %b early %0d want 1 0", done_o, early_done);
    end
    // In DONE, traffic on the inputs must be ignored.
    for (int n = 0; n < 6; n++) begin
      data_valid_i = NK'($urandom());
      data_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
      checks++;
      if (ram_wren_o !== 1'b0 || done_o !== 1'b1 || hold_data_o !== '0) begin
        errors++;
        $display("FAIL done_idle%0d: got wren %b done %b hold %b want 0 1 0000",
                 n, ram_wren_o, done_o, hold_data_o);
      end
    end
    data_valid_i = '0;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] w;
    int            restart;
    do_reset();
    for (int i = 0; i < OS; i++) begin
      w              = $urandom();
      data_valid_i   = 4'b0001;
      data_i[0 +: DW] = w;
      exp_mem[i]     = w;
      acc_cnt[0]++;
      cycle();
      data_valid_i = '0;
      cycle();
    end
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got %b want 0", overrun_o);
    end
    data_valid_i    = 4'b0001;
    data_i[0 +: DW] = 32'hDEADBEEF;
    cycle();
    data_valid_i = '0;
    checks++;
    if (overrun_o !== 1'b1 || ram_wren_o !== 1'b0 || hold_data_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_flag: got overrun %b wren %b hold0 %b want 1 0 0",
               overrun_o, ram_wren_o, hold_data_o[0]);
    end
    run_lanes(0, 400);
    checks++;
    if (stats_at < 0 || overrun_o !== 1'b1 || log_addr.size() !== STATS + 1) begin
      errors++;
      $display("FAIL ovr_finish: got stats_at %0d overrun %b writes %0d want >=0 1 %0d",
               stats_at, overrun_o, log_addr.size(), STATS + 1);
    end
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    restart = cyc_no;
    clear_model();
    checks++;
    if (overrun_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_start: got overrun %b done %b want 0 0", overrun_o, done_o);
    end
    w               = $urandom();
    data_valid_i    = 4'b0001;
    data_i[0 +: DW] = w;
    exp_mem[0]      = w;
    acc_cnt[0]      = 1;
    cycle();
    data_valid_i = '0;
    cycle();
    checks++;
    if (ram_wren_o !== 1'b1 || ram_wraddress_o !== '0 || ram_data_o !== w) begin
      errors++;
      $display("FAIL ovr_restart_w0: got wren %b addr %0d data %h want 1 0 %h",
               ram_wren_o, ram_wraddress_o, ram_data_o, w);
    end
    run_lanes(0, 400);
    checks++;
    if (stats_at < 0 || log_data[log_data.size()-1] !== DW'(stats_at - restart - 1)) begin
      errors++;
      $display("FAIL ovr_restart_cyc: got stats_at %0d data %0d want cyc %0d",
               stats_at, log_data[log_data.size()-1], stats_at - restart - 1);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen [STATS];
    int n_data;
    do_reset();
    run_lanes(5, 200);
    checks++;
    if (log_addr.size() < 5) begin
      errors++;
      $display("FAIL mid_prefix: got %0d writes want at least 5", log_addr.size());
    end
    reset_i      = 1'b1;
    data_valid_i = '0;
    cycle();
    checks++;
    if (ram_wren_o !== 1'b0 || ram_wraddress_o !== '0 || ram_data_o !== '0 ||
        hold_data_o !== '0 || done_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got wren %b addr %h data %h hold %b done %b ovr %b want all 0",
               ram_wren_o, ram_wraddress_o, ram_data_o, hold_data_o, done_o, overrun_o);
    end
    reset_i       = 1'b0;
    first_collect = cyc_no;
    clear_model();
    run_lanes(0, 400);
    for (int a = 0; a < STATS; a++) seen[a] = 1'b0;
    n_data = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] < AW'(STATS)) begin
        n_data++;
        if (log_data[i] !== exp_mem[log_addr[i]] || seen[log_addr[i]]) begin
          errors++;
          $display("FAIL mid_word: addr %0d got %h want %h (dup %0b)",
                   log_addr[i], log_data[i], exp_mem[log_addr[i]], seen[log_addr[i]]);
        end
        seen[log_addr[i]] = 1'b1;
      end else if (log_addr[i] == AW'(STATS)) begin
        if (log_data[i] !== DW'(stats_at - first_collect - 1)) begin
          errors++;
          $display("FAIL mid_cyc: got %0d want %0d", log_data[i], stats_at - first_collect - 1);
        end
      end else begin
        errors++;
        $display("FAIL mid_addr: got %0d want below %0d", log_addr[i], STATS + 1);
      end
    end
    checks++;
    if (n_data !== STATS || stats_at < 0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_complete: got %0d writes stats_at %0d done %b want %0d >=0 1",
               n_data, stats_at, done_o, STATS);
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    start_i      = 1'b0;
    data_valid_i = '0;
    data_i       = '0;
    test_reset();
    test_single_latency();
    test_contention();
    test_back_pressure();
    test_completion();
    test_overrun();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
